lsu_sequencer: RTL and testbench
================================

Name: lsu_sequencer

Overview:
- Multi-cycle controller that sequences one load or store at a time between the register file and data memory.
- Accepts a decoded instruction (opcode, rdst, address) from the issue stage.
- Drives the register-file read and write ports and the memory read and write strobes, and waits on a memory ready handshake.
- Reports completion, or a timeout error, back to the issue stage.

Parameters:
- AW, 22, memory address width
- DW, 32, data width for register file and memory
- RW, 5, register index width
- TIMEOUT, 255, maximum cycles to wait for memready before aborting (must be ≥2)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  instruction valid; sampled only in IDLE
- opcode  in  5  [4]=memory op, [3]=1 store / 0 load
- rdst  in  RW  register index (store source / load destination)
- address  in  AW  memory address
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- err  out  1  valid only with done; 1 = memory timeout
- regsrc1  out  RW  register-file read index
- regread  out  1  register-file read strobe
- regout1  in  DW  register-file read data (combinational, same cycle)
- regdst  out  RW  register-file write index
- regin  out  DW  register-file write data
- regwrite  out  1  register-file write strobe
- memaddress  out  AW  memory address
- memin  out  DW  memory write data
- memout  in  DW  memory read data, valid when memready=1
- memread  out  1  memory read request, held until ready
- memwrite  out  1  memory write request, held until ready
- memready  in  1  memory accepts or completes the current request

Behaviour:
- Reset: state=IDLE. All outputs 0. Latched rdst, address, data and wait counter = 0. Asserting reset mid-operation drops all strobes immediately; nothing is committed.
- States: IDLE, REGRD, MEMWR, MEMRD, REGWR, DONE. Strobes are decoded from state; index, address and data outputs come from latched registers.
- IDLE:
  - busy=0.
  - start=1 with opcode[4]=1 latches rdst and address. Next state is REGRD if opcode[3]=1, otherwise MEMRD.
  - start=1 with opcode[4]=0 is ignored: no busy, no done.
- REGRD (store only): regread=1, regsrc1=rdst. regout1 is captured into the data register at the clock edge. Next state is MEMWR. Duration is exactly one cycle.
- MEMWR:
  - memwrite=1, memaddress=address, memin=captured data, held stable.
  - memready=1 → DONE with err=0.
- MEMRD:
  - memread=1, memaddress=address, held stable.
  - memready=1 → capture memout, go to REGWR.
- Wait counter: cleared on entry to MEMWR/MEMRD; increments each cycle memready=0. If it reaches TIMEOUT-1 with memready still 0, go to DONE with err=1. A timed-out load never writes the register file.
- REGWR: regwrite=1, regdst=rdst, regin=captured memout, for exactly one cycle. Next state is DONE.
- DONE: done=1 (one cycle), err as set, busy=0. Next state is IDLE. start is ignored in DONE.
- busy=1 in REGRD, MEMWR, MEMRD and REGWR.
- Exclusivity: at most one of regread, regwrite, memread, memwrite is 1 in any cycle.
- Latency with zero wait states:
  - Store: start at cycle T → regread at T+1, memwrite at T+2, done at T+3.
  - Load: memread at T+1, regwrite at T+2, done at T+3.
  - Each wait cycle adds 1.
- memready outside MEMRD/MEMWR is ignored.
- err is cleared on entry to REGRD or MEMRD.

Decomposition:
- Shared package: state encoding enum; opcode field positions (OP_MEM=4, OP_STORE=3); default width constants AW/DW/RW.
- One natural sub-module: lsu_wait_timer (loadable counter with clear, enable and expiry flag). The FSM and datapath latches stay in the top module.

Test Plan:
- Store, zero wait:
  - Stimulus: start with opcode=5'b11000, rdst=7, address=22'h00ABCD; regout1=32'hDEADBEEF; memready tied 1.
  - Required: regread with regsrc1=7 at T+1; memwrite with memaddress=22'h00ABCD and memin=32'hDEADBEEF at T+2; done=1, err=0 at T+3.
- Load with 3 wait states:
  - Stimulus: start with opcode=5'b10000, rdst=12, address=22'h000100; memready=1 on the 4th MEMRD cycle with memout=32'h12345678.
  - Required: memread held 4 cycles; regwrite with regdst=12 and regin=32'h12345678 for one cycle; done at T+6.
- Timeout:
  - Stimulus: load with TIMEOUT=4; memready held 0.
  - Required: memread for 4 cycles; then done=1 with err=1; regwrite never asserted.
- Non-memory opcode and back-to-back:
  - Stimulus: start with opcode=5'b00101 in IDLE.
  - Required: busy stays 0, no strobes, no done.
  - Stimulus: a second start held high through DONE.
  - Required: that start is accepted only in the following IDLE cycle.
- Reset mid-operation:
  - Stimulus: deassert rst_n while in MEMWR.
  - Required: memwrite, busy and done drop to 0 asynchronously; after release, state is IDLE and a new load completes normally.

Source files
------------

// File: rtl/lsu_sequencer_pkg.sv
// Shared types and constants for the load/store sequencer.
// State encoding, opcode field positions and default bus widths.
package lsu_sequencer_pkg;

  localparam int AW_DEF   = 22;
  localparam int DW_DEF   = 32;
  localparam int RW_DEF   = 5;

  localparam int OP_MEM   = 4;
  localparam int OP_STORE = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REGRD,
    S_MEMWR,
    S_MEMRD,
    S_REGWR,
    S_DONE
  } state_t;

endpackage

// File: rtl/lsu_wait_timer.sv
// Memory wait counter: cleared while clr is high, counts while en is high.
// expired flags the last allowed wait cycle (count == TIMEOUT-1).
module lsu_wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/lsu_sequencer.sv
// One-at-a-time load/store sequencer between register file and data memory.
// Strobes decode from state; index/address/data outputs come from latched registers.
module lsu_sequencer
  import lsu_sequencer_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int RW      = RW_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [4:0]    opcode,
  input  logic [RW-1:0] rdst,
  input  logic [AW-1:0] address,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [RW-1:0] regsrc1,
  output logic          regread,
  input  logic [DW-1:0] regout1,
  output logic [RW-1:0] regdst,
  output logic [DW-1:0] regin,
  output logic          regwrite,
  output logic [AW-1:0] memaddress,
  output logic [DW-1:0] memin,
  input  logic [DW-1:0] memout,
  output logic          memread,
  output logic          memwrite,
  input  logic          memready
);

  state_t        state_q, state_d;
  logic [RW-1:0] rdst_q, rdst_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          err_q, err_d;

  logic          in_mem;
  logic          tmr_expired;
  logic          unused_opcode_bits;

  assign unused_opcode_bits = ^opcode[2:0];

  assign in_mem = (state_q == S_MEMWR) || (state_q == S_MEMRD);

  // Counter sits at zero outside the memory states, so it is fresh on entry.
  lsu_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (!in_mem),
    .en      (in_mem && !memready),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d = state_q;
    rdst_d  = rdst_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && opcode[OP_MEM]) begin
          rdst_d  = rdst;
          addr_d  = address;
          err_d   = 1'b0;
          state_d = opcode[OP_STORE] ? S_REGRD : S_MEMRD;
        end
      end
      S_REGRD: begin
        data_d  = regout1;
        state_d = S_MEMWR;
      end
      S_MEMWR: begin
        if (memready) begin
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (tmr_expired) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_MEMRD: begin
        if (memready) begin
          data_d  = memout;
          state_d = S_REGWR;
        end else if (tmr_expired) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_REGWR: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rdst_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdst_q  <= rdst_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign busy       = (state_q == S_REGRD) || in_mem || (state_q == S_REGWR);
  assign done       = (state_q == S_DONE);
  assign err        = err_q;
  assign regread    = (state_q == S_REGRD);
  assign regwrite   = (state_q == S_REGWR);
  assign memread    = (state_q == S_MEMRD);
  assign memwrite   = (state_q == S_MEMWR);
  assign regsrc1    = rdst_q;
  assign regdst     = rdst_q;
  assign memaddress = addr_q;
  assign regin      = data_q;
  assign memin      = data_q;

endmodule

// File: tb/tb_lsu_sequencer.sv
// Bench for lsu_sequencer: directed scenarios plus randomized loads/stores
// checked cycle by cycle against a transaction-level timing model.
module tb_lsu_sequencer;

  localparam int AW = 22;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [4:0]    opcode = '0;
  logic [RW-1:0] rdst = '0;
  logic [AW-1:0] address = '0;
  logic          busy, done, err;
  logic [RW-1:0] regsrc1, regdst;
  logic          regread, regwrite, memread, memwrite;
  logic [DW-1:0] regout1 = '0;
  logic [DW-1:0] regin, memin;
  logic [AW-1:0] memaddress;
  logic [DW-1:0] memout = '0;
  logic          memready = 1'b0;

  int checks = 0;
  int failures = 0;

  lsu_sequencer #(.AW(AW), .DW(DW), .RW(RW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .rdst(rdst),
    .address(address), .busy(busy), .done(done), .err(err),
    .regsrc1(regsrc1), .regread(regread), .regout1(regout1),
    .regdst(regdst), .regin(regin), .regwrite(regwrite),
    .memaddress(memaddress), .memin(memin), .memout(memout),
    .memread(memread), .memwrite(memwrite), .memready(memready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one transaction starting in an IDLE cycle and checks every cycle up to DONE.
  // w = memready-low cycles before memready; w >= TO means the request times out.
  // hold: keep start high with the next instruction's fields throughout.
  task automatic run_op(input bit st, input logic [RW-1:0] rd, input logic [AW-1:0] ad,
                        input logic [DW-1:0] dat, input int w, input bit hold,
                        input bit nst, input logic [RW-1:0] nrd, input logic [AW-1:0] nad);
    bit timeout;
    int n_mem, pre, total, k;
    bit ph_rr, ph_mem, ph_rw, ph_dn;
    logic [5:0] exp_v, got_v;
    timeout = (w >= TO);
    n_mem   = timeout ? TO : w + 1;
    pre     = st ? 1 : 0;
    total   = pre + n_mem + ((st || timeout) ? 0 : 1) + 1;

    @(posedge clk); #1;
    start = 1'b1; opcode = st ? 5'b11000 : 5'b10000; rdst = rd; address = ad;
    memready = $urandom_range(0, 1); regout1 = $urandom; memout = $urandom;
    @(negedge clk);
    checks++;
    if ({busy, done, regread, regwrite, memread, memwrite} !== 6'b0) begin
      failures++;
      $display("FAIL idle_before_start: got %b want 000000",
               {busy, done, regread, regwrite, memread, memwrite});
    end

    for (int c = 1; c <= total; c++) begin
      ph_rr  = st && (c == 1);
      ph_mem = (c > pre) && (c <= pre + n_mem);
      ph_dn  = (c == total);
      ph_rw  = !ph_rr && !ph_mem && !ph_dn;
      k      = c - pre - 1;
      @(posedge clk); #1;
      if (hold) begin
        start = 1'b1; opcode = nst ? 5'b11000 : 5'b10000; rdst = nrd; address = nad;
      end else begin
        start = 1'b0; opcode = 5'($urandom); rdst = RW'($urandom); address = AW'($urandom);
      end
      regout1  = ph_rr ? dat : ~dat;
      memready = ph_mem ? (k == w) : 1'($urandom);
      memout   = (ph_mem && k == w && !st) ? dat : ~dat;
      @(negedge clk);
      exp_v = {ph_rr || ph_mem || ph_rw, ph_dn, ph_rr, ph_rw, ph_mem && !st, ph_mem && st};
      got_v = {busy, done, regread, regwrite, memread, memwrite};
      checks++;
      if (got_v !== exp_v) begin
        failures++;
        $display("FAIL strobes st=%0d w=%0d cycle=%0d: got %b want %b (busy,done,rr,rw,mr,mw)",
                 st, w, c, got_v, exp_v);
      end
      if (ph_dn) begin
        checks++;
        if (err !== timeout) begin
          failures++;
          $display("FAIL err st=%0d w=%0d: got %b want %b", st, w, err, timeout);
        end
      end
      if (ph_rr) begin
        checks++;
        if (regsrc1 !== rd) begin
          failures++;
          $display("FAIL regsrc1: got %0d want %0d", regsrc1, rd);
        end
      end
      if (ph_mem) begin
        checks++;
        if (memaddress !== ad || (st && memin !== dat)) begin
          failures++;
          $display("FAIL mem_bus cycle=%0d: addr %h data %h want addr %h data %h",
                   c, memaddress, memin, ad, dat);
        end
      end
      if (ph_rw) begin
        checks++;
        if (regdst !== rd || regin !== dat) begin
          failures++;
          $display("FAIL reg_write: dst %0d data %h want dst %0d data %h", regdst, regin, rd, dat);
        end
      end
    end
  endtask

  task automatic release_start();
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, err, regread, regwrite, memread, memwrite, regsrc1, regdst,
         regin, memin, memaddress} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: some output nonzero busy=%b done=%b err=%b addr=%h data=%h",
               busy, done, err, memaddress, memin);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, err, regread, regwrite, memread, memwrite} !== 7'b0) begin
      failures++;
      $display("FAIL idle_after_reset: got %b want 0",
               {busy, done, err, regread, regwrite, memread, memwrite});
    end
  endtask

  task automatic test_store_zero_wait();
    run_op(1'b1, 5'd7, 22'h00ABCD, 32'hDEADBEEF, 0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_load_wait3();
    run_op(1'b0, 5'd12, 22'h000100, 32'h12345678, 3, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_timeout();
    run_op(1'b0, 5'd3, 22'h3FFFFF, 32'hCAFEF00D, 1000, 1'b0, 1'b0, '0, '0);
    run_op(1'b1, 5'd30, 22'h012345, 32'h0BADC0DE, 1000, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_non_mem();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      start = 1'b1; opcode = 5'b00101; rdst = RW'($urandom); address = AW'($urandom);
      memready = 1'($urandom);
      @(negedge clk);
      checks++;
      if ({busy, done, regread, regwrite, memread, memwrite} !== 6'b0) begin
        failures++;
        $display("FAIL non_mem cycle=%0d: got %b want 000000", i,
                 {busy, done, regread, regwrite, memread, memwrite});
      end
    end
    release_start();
  endtask

  task automatic test_back_to_back();
    run_op(1'b0, 5'd9, 22'h0000AA, 32'h11112222, 1, 1'b1, 1'b1, 5'd21, 22'h155555);
    run_op(1'b1, 5'd21, 22'h155555, 32'h33334444, 2, 1'b1, 1'b0, 5'd4, 22'h2AAAAA);
    run_op(1'b0, 5'd4, 22'h2AAAAA, 32'h55556666, 0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    start = 1'b1; opcode = 5'b11000; rdst = 5'd5; address = 22'h0F0F0F; memready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; regout1 = 32'hA5A5A5A5;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (memwrite !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_setup: memwrite=%b busy=%b want 1 1", memwrite, busy);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({memwrite, busy, done, regread, regwrite, memread} !== 6'b0) begin
      failures++;
      $display("FAIL reset_mid_async: got %b want 000000",
               {memwrite, busy, done, regread, regwrite, memread});
    end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, err, memwrite, memread} !== 5'b0) begin
      failures++;
      $display("FAIL reset_mid_release: got %b want 00000", {busy, done, err, memwrite, memread});
    end
    run_op(1'b0, 5'd17, 22'h000777, 32'h89ABCDEF, 1, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      run_op(1'($urandom), RW'($urandom), AW'($urandom), $urandom,
             $urandom_range(0, TO + 1), 1'b0, 1'b0, '0, '0);
      if ($urandom_range(0, 1) == 1) release_start();
    end
  endtask

  initial begin
    test_reset();
    test_store_zero_wait();
    test_load_wait3();
    test_timeout();
    test_non_mem();
    test_back_to_back();
    test_reset_mid();
    test_random();
    release_start();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
